lut_sym_decoder: RTL and testbench

Sequential inverse of the symbol-weight LUT. The forward table gives each symbol k a weight of STEP*(N-k) for k < N and 0 otherwise. Given N and a received code value, this block scans the symbols and returns the first symbol whose weight does not exceed the code, plus an exact-match flag. It sits on the receive side, after the code field is extracted, and uses valid/ready handshakes on both ends.

---
 rtl/lut_sym_decoder_if.sv | 25 ++
 rtl/lut_sym_decoder.sv | 96 +++++++++
 tb/tb_lut_sym_decoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lut_sym_decoder_if.sv
// Request/result handshake bundle for lut_sym_decoder.
// The master side issues requests and takes results; the slave side is the decoder.
interface lut_sym_decoder_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] n;
  logic [DATA_WIDTH-1:0] code;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] sym;
  logic                  hit;

  modport master (
    output in_valid, n, code, out_ready,
    input  in_ready, out_valid, sym, hit
  );

  modport slave (
    input  in_valid, n, code, out_ready,
    output in_ready, out_valid, sym, hit
  );
endinterface

// File: rtl/lut_sym_decoder.sv
// Sequential inverse of the symbol-weight LUT: finds the first symbol whose weight is <= code.
// Optional miss counter port enabled by defining LUT_DEC_STATS_EN.
module lut_sym_decoder #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 6,
  parameter int STEP       = 4
) (
  input  logic               clk,
  input  logic               rst,
  lut_sym_decoder_if.slave   bus
`ifdef LUT_DEC_STATS_EN
  ,
  output logic [15:0]        miss_cnt
`endif
);

  localparam logic [DATA_WIDTH-1:0] STEP_W = DATA_WIDTH'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] k;
  logic [DATA_WIDTH-1:0] w;
  logic [DATA_WIDTH-1:0] code_q;
  logic [ADDR_WIDTH-1:0] sym_q;
  logic                  hit_q;
  logic                  in_ready_q;
  logic                  out_valid_q;

  // Weights fall by STEP per symbol, so the scan walks w down from STEP*n
  // and always stops at k = n at the latest, where w reaches 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      w           <= '0;
      code_q      <= '0;
      sym_q       <= '0;
      hit_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef LUT_DEC_STATS_EN
      miss_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            code_q     <= bus.code;
            k          <= '0;
            w          <= STEP_W * DATA_WIDTH'(bus.n);
            in_ready_q <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (w <= code_q) begin
            sym_q       <= k;
            hit_q       <= (w == code_q);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            k <= k + 1'b1;
            w <= w - STEP_W;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
`ifdef LUT_DEC_STATS_EN
            if (!hit_q && (miss_cnt != 16'hFFFF))
              miss_cnt <= miss_cnt + 16'd1;
`endif
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sym       = sym_q;
  assign bus.hit       = hit_q;

endmodule

// File: tb/tb_lut_sym_decoder.sv
// Directed self-checking bench for lut_sym_decoder; expected values are hand-computed.
// Miss-counter checks are compiled in only when LUT_DEC_STATS_EN is defined.
module tb_lut_sym_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_miss = 0;

  lut_sym_decoder_if #(.ADDR_WIDTH(4), .DATA_WIDTH(6)) bus ();

`ifdef LUT_DEC_STATS_EN
  logic [15:0] miss_cnt;
`endif

  lut_sym_decoder #(.ADDR_WIDTH(4), .DATA_WIDTH(6), .STEP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave)
`ifdef LUT_DEC_STATS_EN
    ,
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkMiss(input string tag);
`ifdef LUT_DEC_STATS_EN
    checkOutput(tag, 32'(miss_cnt), 32'(exp_miss));
`endif
  endtask

  // One full request/result transaction. Inputs change #1 after a rising edge.
  task automatic applyStimulus(input int nv, input int cv, input int exp_sym, input int exp_hit,
                               input int exp_lat, input int hold, input bit pulse);
    int lat;
    checkOutput("in_ready_idle", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.n        = 4'(nv);
    bus.code     = 6'(cv);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.n        = 4'd0;
    bus.code     = 6'd63;
    checkOutput("in_ready_busy", 32'(bus.in_ready), 0);
    lat = 0;
    while (lat < 40) begin
      if (pulse) bus.in_valid = ~bus.in_valid;
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) break;
    end
    bus.in_valid = 1'b0;
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("sym", 32'(bus.sym), 32'(exp_sym));
    checkOutput("hit", 32'(bus.hit), 32'(exp_hit));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(bus.out_valid), 1);
      checkOutput("hold_sym", 32'(bus.sym), 32'(exp_sym));
      checkOutput("hold_hit", 32'(bus.hit), 32'(exp_hit));
      checkOutput("hold_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    if (exp_hit == 0) exp_miss++;
    checkOutput("xfer_valid", 32'(bus.out_valid), 0);
    checkOutput("xfer_in_ready", 32'(bus.in_ready), 1);
    checkMiss("miss_cnt");
    @(posedge clk); #1;
    checkOutput("no_extra_result", 32'(bus.out_valid), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b1;
    bus.n         = 4'd5;
    bus.code      = 6'd12;
    bus.out_ready = 1'b0;
    // Reset with in_valid high: reset must win.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_sym", 32'(bus.sym), 0);
    checkOutput("rst_hit", 32'(bus.hit), 0);
    checkMiss("rst_miss_cnt");
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_after_rst", 32'(bus.in_ready), 1);

    applyStimulus(5, 12, 2, 1, 3, 0, 1'b0);
    applyStimulus(5, 13, 2, 0, 3, 0, 1'b0);
    applyStimulus(5, 63, 0, 0, 1, 0, 1'b0);
    applyStimulus(15, 0, 15, 1, 16, 0, 1'b1);
    applyStimulus(0, 0, 0, 1, 1, 0, 1'b0);
    applyStimulus(0, 5, 0, 0, 1, 0, 1'b0);
    applyStimulus(15, 59, 1, 0, 2, 0, 1'b0);
    applyStimulus(15, 60, 0, 1, 1, 0, 1'b0);
    applyStimulus(5, 12, 2, 1, 3, 5, 1'b1);

    // Abort a long scan with reset on its 4th edge.
    bus.in_valid = 1'b1;
    bus.n        = 4'd15;
    bus.code     = 6'd0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_miss = 0;
    checkOutput("abort_in_ready", 32'(bus.in_ready), 1);
    checkOutput("abort_out_valid", 32'(bus.out_valid), 0);
    checkOutput("abort_sym", 32'(bus.sym), 0);
    checkMiss("abort_miss_cnt");
    applyStimulus(3, 4, 2, 1, 3, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
